// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: byte-wide UART transmitter fed by a small circular write FIFO.
// Stores are accepted one byte per cycle while we is high; bytes leave on tx
// as 8N1 frames, LSB first, back-to-back with no idle gap while queued.
// Build option: define UART_TX_PARITY_EN to add an even-parity bit (8E1).
module uart_tx_fifo #(
    parameter int CLKS_PER_BIT = 868,
    parameter int FIFO_DEPTH   = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          we,
    input  logic [7:0]                    in_data,
    output logic                          tx,
    output logic                          busy,
    output logic                          full,
    output logic                          overflow,
    output logic [$clog2(FIFO_DEPTH):0]   level
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;
    localparam int CW = $clog2(CLKS_PER_BIT);

    localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [LW-1:0] LVL_FULL  = LW'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef UART_TX_PARITY_EN
        S_PARITY,
`endif
        S_STOP
    } state_t;

    // FIFO storage and bookkeeping
    logic [7:0]    r_mem [FIFO_DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [LW-1:0] r_level;
    logic          r_overflow;

    // Transmitter state
    state_t        r_state;
    state_t        w_state_nxt;
    logic [CW-1:0] r_baud;
    logic [2:0]    r_bit_idx;
    logic [7:0]    r_shift;
    logic [7:0]    w_shift_nxt;
    logic          r_tx;
    logic          w_tx_nxt;
`ifdef UART_TX_PARITY_EN
    logic          r_parity;
`endif

    logic       w_bit_end;
    logic       w_pop;
    logic       w_push;
    logic       w_full;
    logic [7:0] w_head;

    assign w_full    = (r_level == LVL_FULL);
    assign w_bit_end = (r_baud == BAUD_LAST);
    assign w_head    = r_mem[r_rptr];

    // A pop starts a frame from IDLE, or chains the next frame at the very end of STOP.
    assign w_pop  = (r_level != '0) &&
                    ((r_state == S_IDLE) || ((r_state == S_STOP) && w_bit_end));
    // A full FIFO still accepts a byte when the head leaves in the same cycle.
    assign w_push = we && (!w_full || w_pop);

    // FIFO storage write
    // NOTE: the data array has no reset; stale entries are unreachable because
    // the pointers and occupancy count are reset, so a reset here only costs logic.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= in_data;
        end
    end

    // FIFO pointers, occupancy and the registered drop indicator
    // NOTE: sequential state is always updated with <= so every register samples
    // the pre-edge values of its neighbours regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_level    <= '0;
            r_overflow <= 1'b0;
        end else begin
            r_overflow <= we && w_full && !w_pop;
            if (w_push) begin
                r_wptr <= r_wptr + AW'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + LW'(1);
                2'b01:   r_level <= r_level - LW'(1);
                default: r_level <= r_level;
            endcase
        end
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next-state logic
    // NOTE: every combinational output gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_pop) begin
                    w_state_nxt = S_START;
                end
            end
            S_START: begin
                if (w_bit_end) begin
                    w_state_nxt = S_DATA;
                end
            end
            S_DATA: begin
                if (w_bit_end && (r_bit_idx == 3'd7)) begin
`ifdef UART_TX_PARITY_EN
                    w_state_nxt = S_PARITY;
`else
                    w_state_nxt = S_STOP;
`endif
                end
            end
`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
                if (w_bit_end) begin
                    w_state_nxt = S_STOP;
                end
            end
`endif
            S_STOP: begin
                if (w_bit_end) begin
                    w_state_nxt = w_pop ? S_START : S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Shift register next value: load the FIFO head on pop, shift right at each data bit end
    always_comb begin
        w_shift_nxt = r_shift;
        if (w_pop) begin
            w_shift_nxt = w_head;
        end else if ((r_state == S_DATA) && w_bit_end) begin
            w_shift_nxt = {1'b0, r_shift[7:1]};
        end
    end

    // FSM output logic: line level for the state about to be entered, registered below
    always_comb begin
        w_tx_nxt = 1'b1;
        case (w_state_nxt)
            S_START:  w_tx_nxt = 1'b0;
            S_DATA:   w_tx_nxt = w_shift_nxt[0];
`ifdef UART_TX_PARITY_EN
            S_PARITY: w_tx_nxt = r_parity;
`endif
            default:  w_tx_nxt = 1'b1;
        endcase
    end

    // Bit timing, shift register and the glitch-free registered serial line
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_baud    <= '0;
            r_bit_idx <= '0;
            r_shift   <= '0;
            r_tx      <= 1'b1;
`ifdef UART_TX_PARITY_EN
            r_parity  <= 1'b0;
`endif
        end else begin
            r_shift <= w_shift_nxt;
            r_tx    <= w_tx_nxt;
            // Baud counter restarts on every state entry and at each bit boundary
            if ((w_state_nxt != r_state) || (r_state == S_IDLE) || w_bit_end) begin
                r_baud <= '0;
            end else begin
                r_baud <= r_baud + CW'(1);
            end
            if (r_state != S_DATA) begin
                r_bit_idx <= '0;
            end else if (w_bit_end) begin
                r_bit_idx <= r_bit_idx + 3'd1;
            end
`ifdef UART_TX_PARITY_EN
            if (w_pop) begin
                r_parity <= ^w_head;
            end
`endif
        end
    end

    assign tx       = r_tx;
    assign busy     = (r_state != S_IDLE) || (r_level != '0);
    assign full     = w_full;
    assign overflow = r_overflow;
    assign level    = r_level;

endmodule

// File: doc/uart_tx_fifo.md
# uart_tx_fifo

Byte-wide UART transmitter with a small write FIFO, driving the board's serial TX pin. Sits directly downstream of the data memory. It consumes the memory's UART store byte and its one-cycle write strobe, generated when the CPU stores to 0xf6fff070. It returns the serial line that the memory forwards to the FPGA pin. The FIFO lets the CPU issue back-to-back stores without polling.

## Interface
- CLKS_PER_BIT, default 868: clock cycles per serial bit (100 MHz / 115200). Must be ≥ 2.
- FIFO_DEPTH, default 16: FIFO entries. Must be a power of two, ≥ 2.
- clk  input  1  system clock; all logic on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- we  input  1  push strobe; one byte pushed per cycle while high.
- in_data  input  8  byte to push, sampled when we=1.
- tx  output  1  serial line, idle high, 8N1 format, LSB first.
- busy  output  1  high while the FIFO is non-empty or a frame is in progress.
- full  output  1  high when level == FIFO_DEPTH.
- overflow  output  1  one-cycle pulse when a push is dropped.
- level  output  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.

## Operation
- FIFO
  - Circular buffer with read/write pointers of $clog2(FIFO_DEPTH) bits that wrap modulo the depth, plus a separate occupancy count.
- Push
  - we=1 and level<FIFO_DEPTH: write in_data at wptr, wptr+1.
  - we=1 and full, with a pop in the same cycle: push accepted; level unchanged.
  - we=1 and full, with no pop: byte dropped, overflow=1 for that cycle.
- Pop
  - Occurs in IDLE when level>0, or on the last cycle of STOP when level>0.
  - Loads shift register from rptr, rptr+1.
- FSM states: IDLE, START, DATA, STOP (plus PARITY, see Configuration).
  - IDLE: tx=1. On pop → START.
  - START: tx=0 for CLKS_PER_BIT cycles → DATA.
  - DATA: tx=shift[0] per bit. Shift right and increment bit index each CLKS_PER_BIT cycles. After bit 7 → STOP.
  - STOP: tx=1 for CLKS_PER_BIT cycles. At the end: if level>0, pop and go to START (no idle gap); else → IDLE.
- Baud counter
  - Counts 0..CLKS_PER_BIT-1 and is cleared on every state entry.
  - A bit ends when the counter == CLKS_PER_BIT-1.
- tx is registered; it never glitches.
- busy = (state != IDLE) | (level != 0).

## Timing
- Reset (asynchronous, any time, including mid-frame):
  - tx=1, busy=0, full=0, overflow=0, level=0.
  - Pointers cleared, FSM→IDLE. Queued and in-flight bytes are discarded.
- Push at edge N (FIFO empty, IDLE): level=1 after N. Pop at N+1; tx=0 after N+1.
- Latency from we to the start bit: 2 edges.
- Frame length: exactly 10·CLKS_PER_BIT cycles. Consecutive queued frames are contiguous.
- full and level update on the edge of the push/pop. overflow is registered and high for the cycle after the dropped push's edge.
- With pop and push in the same cycle, level is unchanged; the popped entry is the old head, and it is never the newly written byte unless level was 0.

## Configuration
- UART_TX_PARITY_EN
  - Defined: a PARITY state between DATA and STOP drives even parity (XOR of the 8 data bits) for CLKS_PER_BIT cycles. Frame = 11·CLKS_PER_BIT cycles (8E1).
  - Undefined: no PARITY state; 8N1, 10·CLKS_PER_BIT cycles.

## Test plan
- CLKS_PER_BIT=4, one push of 0x55 → tx low at edge 2, line pattern 0,1,0,1,0,1,0,1,0,1 each 4 cycles, busy falls 42 cycles after the push.
- Push 0x01, 0x80, 0xFF on 3 consecutive cycles → 120 contiguous frame cycles with no idle high between stop and next start; level peaks at 2.
- FIFO_DEPTH=4, 7 pushes on consecutive cycles → bytes 0–4 transmitted in order, bytes 5–6 dropped, overflow high for exactly 2 cycles, full high while level=4.
- full FIFO with push coinciding with the end-of-STOP pop → push accepted, level stays 4, no overflow.
- rst_n low during DATA bit 3 → tx=1 immediately (asynchronous), level=0, busy=0; a later push of 0xA5 transmits cleanly.
- UART_TX_PARITY_EN defined, push 0x07 → parity bit 1, frame 44 cycles at CLKS_PER_BIT=4; push 0x03 → parity bit 0.
